maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_stream.sv | 102 ++++++++++
 tb/tb_maxpool_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order feature map.
// Optional build macro: MAXPOOL_SIGNED_EN selects two's-complement comparisons.
module maxpool_stream #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBN = IMG_W / 2;
    localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] h_max;
    logic [DATA_W-1:0] lb [LBN];
    logic [LBW-1:0]    lb_idx;
    logic              in_xfer;
    logic              out_xfer;
    logic              col_last;
    logic              row_last;
    logic              win_done;
    logic [DATA_W-1:0] pair_max;
    logic [DATA_W-1:0] win_max;

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        sa = a;
        sb = b;
        return (sa > sb) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    assign in_ready = !(out_valid && !out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_idx   = LBW'(col >> 1);
    assign win_done = in_xfer && col[0] && row[0];
    assign pair_max = max2(h_max, in_data);
    assign win_max  = max2(lb[lb_idx], pair_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            h_max     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (restart) begin
            col       <= '0;
            row       <= '0;
            h_max     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (in_xfer) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) begin
                    row <= row_last ? '0 : row + 1'b1;
                end
                if (!col[0]) begin
                    h_max <= in_data;
                end
            end
            // A completing window overwrites a result leaving on the same edge.
            if (win_done) begin
                out_valid <= 1'b1;
                out_data  <= win_max;
                out_last  <= row_last && col_last;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Line buffer holds the top-row pair maxima; each entry is written before it is read.
    always_ff @(posedge clk) begin
        if (in_xfer && !restart && col[0] && !row[0]) begin
            lb[lb_idx] <= pair_max;
        end
    end
endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream (DATA_W=4, 4x4 frames): table frames,
// stall/reset/restart sequences and a randomized run against a frame-array model.
module tb_maxpool_stream;
    localparam int DW = 4;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NP = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          restart;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    maxpool_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP-1:0][DW-1:0] pix;
        logic [3:0][DW-1:0]    exp;
    } vec_t;

    int passes = 0;
    int total  = 0;

    logic [DW-1:0] frame [NP];
    int            n_idx = 0;
    int            acc_cnt = 0;
    logic [DW-1:0] exp_d [$];
    logic          exp_l [$];
    logic [DW-1:0] got_d [$];
    logic          got_l [$];
    logic          pend = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    // Reference model: store accepted pixels by raster index, pool each completed window.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_idx = 0;
            exp_d.delete();
            exp_l.delete();
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("latency_valid", int'(out_valid), 1);
                check("latency_data", int'(out_data), int'(exp_d[$]));
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("out_not_extra", int'(exp_d.size() != 0), 1);
                if (exp_d.size() != 0) begin
                    check("out_data", int'(out_data), int'(exp_d[0]));
                    check("out_last", int'(out_last), int'(exp_l[0]));
                    void'(exp_d.pop_front());
                    void'(exp_l.pop_front());
                end
                got_d.push_back(out_data);
                got_l.push_back(out_last);
            end
            if (restart) begin
                n_idx = 0;
                exp_d.delete();
                exp_l.delete();
                pend = 1'b0;
            end else if (in_valid && in_ready) begin
                int r;
                int c;
                logic [DW-1:0] m;
                frame[n_idx] = in_data;
                acc_cnt++;
                r = n_idx / W;
                c = n_idx % W;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m = mx(mx(frame[(r-1)*W + c-1], frame[(r-1)*W + c]),
                           mx(frame[r*W + c-1], frame[r*W + c]));
                    exp_d.push_back(m);
                    exp_l.push_back(n_idx == NP - 1);
                    pend = 1'b1;
                end
                n_idx = (n_idx + 1) % NP;
            end
        end
    end

    task automatic send(input logic [DW-1:0] p);
        int   t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = p;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_got4(input string name, input logic [3:0][DW-1:0] e);
        check({name, "_count"}, got_d.size(), 4);
        if (got_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check({name, "_data"}, int'(got_d[i]), int'(e[i]));
                check({name, "_last"}, int'(got_l[i]), (i == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic check_reset_outs(input string name);
        @(negedge clk);
        check({name, "_out_valid"}, int'(out_valid), 0);
        check({name, "_out_data"}, int'(out_data), 0);
        check({name, "_out_last"}, int'(out_last), 0);
        check({name, "_in_ready"}, int'(in_ready), 1);
    endtask

    vec_t tbl [4];

    initial begin
        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        for (int i = 0; i < NP; i++) begin
            tbl[0].pix[i] = DW'(i);
            tbl[1].pix[i] = DW'(NP - 1 - i);
            tbl[2].pix[i] = '0;
            tbl[3].pix[i] = 4'h9;
        end
        tbl[0].exp = {4'd15, 4'd13, 4'd7, 4'd5};
        tbl[1].exp = {4'd5, 4'd7, 4'd13, 4'd15};
        tbl[2].pix[0] = 4'hF; tbl[2].pix[1] = 4'h8; tbl[2].pix[4] = 4'h1; tbl[2].pix[5] = 4'hE;
`ifdef MAXPOOL_SIGNED_EN
        tbl[2].exp = {4'h0, 4'h0, 4'h0, 4'h1};
`else
        tbl[2].exp = {4'h0, 4'h0, 4'h0, 4'hF};
`endif
        tbl[3].exp = {4'h9, 4'h9, 4'h9, 4'h9};

        check_reset_outs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        for (int v = 0; v < 4; v++) begin
            got_d.delete(); got_l.delete();
            for (int i = 0; i < NP; i++) send(tbl[v].pix[i]);
            idle(3);
            check_got4($sformatf("frame%0d", v), tbl[v].exp);
        end

        // Downstream stall from the first result onward.
        got_d.delete(); got_l.delete();
        acc_cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(DW'(i));
        in_valid = 1'b1;
        in_data  = 4'd6;
        idle(10);
        @(negedge clk);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_out_data", int'(out_data), 5);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_accepted", acc_cnt, 6);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 6; i < NP; i++) send(DW'(i));
        idle(3);
        check_got4("stall", tbl[0].exp);

        // Asynchronous reset mid-frame, then a frame of nines.
        for (int i = 0; i < 6; i++) send(DW'(i + 3));
        rst_n = 1'b0;
        check_reset_outs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        got_d.delete(); got_l.delete();
        for (int i = 0; i < NP; i++) send(4'h9);
        idle(3);
        check_got4("after_rst", tbl[3].exp);

        // Restart collides with pixel 3.
        for (int i = 0; i < 3; i++) send(DW'(i));
        in_valid = 1'b1; in_data = 4'd3; restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; in_valid = 1'b0;
        got_d.delete(); got_l.delete();
        for (int i = 0; i < NP; i++) send(tbl[1].pix[i]);
        idle(3);
        check_got4("restart", tbl[1].exp);

        // Random valid with out_ready toggling every cycle.
        begin
            int cnt;
            int cyc;
            logic a;
            got_d.delete(); got_l.delete();
            acc_cnt = 0;
            cnt = 0;
            cyc = 0;
            while (cnt < 3 * NP && cyc < 3000) begin
                out_ready = ~out_ready;
                if (!in_valid) begin
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = DW'($urandom);
                end
                @(negedge clk);
                a = in_valid && in_ready;
                @(posedge clk); #1;
                if (a) begin
                    cnt++;
                    in_valid = 1'b0;
                end
                cyc++;
            end
            check("rand_all_sent", cnt, 3 * NP);
            in_valid = 1'b0;
            out_ready = 1'b1;
            idle(5);
            check("rand_accepted", acc_cnt, 3 * NP);
            check("rand_results", got_d.size(), 12);
            check("rand_none_lost", exp_d.size(), 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
